// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: op field width and op encodings.
package pc_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_SEQ  = 3'd0;
  localparam logic [OP_W-1:0] OP_JMP  = 3'd1;
  localparam logic [OP_W-1:0] OP_BR   = 3'd2;
  localparam logic [OP_W-1:0] OP_CALL = 3'd3;
  localparam logic [OP_W-1:0] OP_RET  = 3'd4;
  localparam logic [OP_W-1:0] OP_HOLD = 3'd5;

endpackage

// File: rtl/pc_unit_return_stack.sv
// Hardware return-address stack: strict LIFO with a combinational top-of-stack read.
// The caller never pushes when full or pops when empty.
module return_stack #(
  parameter int WIDTH       = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [PTR_W-1:0]       sp_reg;
  logic [WIDTH-1:0]       mem [STACK_DEPTH];
  logic [STACK_DEPTH-1:0] entry_we;
  logic [IDX_W-1:0]       top_idx;

  // One write enable per entry; the pointer selects which slot the push lands in.
  genvar gi;
  generate
    for (gi = 0; gi < STACK_DEPTH; gi++) begin : g_entry_we
      assign entry_we[gi] = push && (sp_reg == PTR_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (entry_we[i]) begin
        mem[i] <= din;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      sp_reg <= '0;
    end else if (push) begin
      sp_reg <= sp_reg + 1'b1;
    end else if (pop) begin
      sp_reg <= sp_reg - 1'b1;
    end
  end

  // When empty the index wraps; dout is then unused by the caller.
  assign top_idx = IDX_W'(sp_reg - 1'b1);
  assign dout    = mem[top_idx];
  assign full    = (sp_reg == PTR_W'(STACK_DEPTH));
  assign empty   = (sp_reg == '0);

endmodule

// File: rtl/pc_unit.sv
// Program counter with increment, jump, relative branch, call/return via a hardware
// return stack, and stall. pc_next is the value pc_out takes at the next edge.
module pc_unit
  import pc_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int STACK_DEPTH  = 4,
  parameter int RESET_VECTOR = 0,
  parameter int INC_STEP     = 1
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             stall,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] offset,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_next,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             stack_err
);

  logic [WIDTH-1:0] pc_reg;
  logic             stack_err_reg;
  logic [WIDTH-1:0] seq_addr;
  logic [WIDTH-1:0] ret_addr;
  logic             push;
  logic             pop;
  logic             err_set;
  logic             active;

  assign seq_addr = pc_reg + WIDTH'(INC_STEP);
  assign active   = !RST && !stall;

  return_stack #(
    .WIDTH       (WIDTH),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_return_stack (
    .clk   (clk),
    .RST   (RST),
    .push  (push),
    .pop   (pop),
    .din   (seq_addr),
    .dout  (ret_addr),
    .full  (stack_full),
    .empty (stack_empty)
  );

  // offset is already WIDTH bits wide, so two's-complement addition is the sign-extended branch.
  always_comb begin
    pc_next = pc_reg;
    if (RST) begin
      pc_next = WIDTH'(RESET_VECTOR);
    end else if (!stall) begin
      case (op)
        OP_SEQ:  pc_next = seq_addr;
        OP_JMP:  pc_next = target;
        OP_BR:   pc_next = pc_reg + offset;
        OP_CALL: pc_next = target;
        OP_RET:  pc_next = stack_empty ? seq_addr : ret_addr;
        default: pc_next = pc_reg;
      endcase
    end
  end

  // Overflowing calls still jump but drop the return address; underflowing returns fall through.
  always_comb begin
    push    = active && (op == OP_CALL) && !stack_full;
    pop     = active && (op == OP_RET) && !stack_empty;
    err_set = active && (((op == OP_CALL) && stack_full) || ((op == OP_RET) && stack_empty));
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      pc_reg        <= WIDTH'(RESET_VECTOR);
      stack_err_reg <= 1'b0;
    end else begin
      pc_reg <= pc_next;
      if (err_set) begin
        stack_err_reg <= 1'b1;
      end
    end
  end

  assign pc_out    = pc_reg;
  assign stack_err = stack_err_reg;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: a queue-based reference model checked every cycle,
// directed sequences with literal expectations, then randomized traffic.
module tb_pc_unit;
  import pc_pkg::*;

  localparam int W     = 8;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         RST = 1'b0;
  logic         stall = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] target = '0;
  logic [W-1:0] offset = '0;
  logic [W-1:0] pc_out;
  logic [W-1:0] pc_next;
  logic         stack_full;
  logic         stack_empty;
  logic         stack_err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [W-1:0] m_pc = '0;
  logic [W-1:0] m_q[$];
  logic         m_err = 1'b0;
  bit           m_valid = 1'b0;

  pc_unit #(
    .WIDTH        (W),
    .STACK_DEPTH  (DEPTH),
    .RESET_VECTOR (0),
    .INC_STEP     (1)
  ) dut (
    .clk         (clk),
    .RST         (RST),
    .stall       (stall),
    .op          (op),
    .target      (target),
    .offset      (offset),
    .pc_out      (pc_out),
    .pc_next     (pc_next),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .stack_err   (stack_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] model_next();
    logic [W-1:0] n;
    n = m_pc;
    if (RST) n = '0;
    else if (!stall) begin
      case (op)
        3'd0: n = m_pc + 8'd1;
        3'd1: n = target;
        3'd2: n = m_pc + offset;
        3'd3: n = target;
        3'd4: n = (m_q.size() > 0) ? m_q[$] : m_pc + 8'd1;
        default: n = m_pc;
      endcase
    end
    return n;
  endfunction

  task automatic model_update();
    logic [W-1:0] n;
    n = model_next();
    if (RST) begin
      m_q.delete();
      m_err = 1'b0;
      m_valid = 1'b1;
    end else if (!stall) begin
      if (op == 3'd3) begin
        if (m_q.size() < DEPTH) m_q.push_back(m_pc + 8'd1);
        else m_err = 1'b1;
      end else if (op == 3'd4) begin
        if (m_q.size() > 0) void'(m_q.pop_back());
        else m_err = 1'b1;
      end
    end
    m_pc = n;
  endtask

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("pc_out",      pc_out,               m_pc);
      check("pc_next",     pc_next,              model_next());
      check("stack_empty", {7'd0, stack_empty},  {7'd0, m_q.size() == 0});
      check("stack_full",  {7'd0, stack_full},   {7'd0, m_q.size() == DEPTH});
      check("stack_err",   {7'd0, stack_err},    {7'd0, m_err});
    end
  end

  // Drive one cycle; returns 1 time unit after the edge that consumed the inputs.
  task automatic step(input logic r, input logic s, input logic [2:0] o,
                      input logic [W-1:0] t, input logic [W-1:0] f);
    RST = r; stall = s; op = o; target = t; offset = f;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic lit(input string name, input logic [W-1:0] exp_pc);
    check(name, pc_out, exp_pc);
    $display("txn %s pc_out=%h empty=%0b full=%0b err=%0b", name, pc_out, stack_empty, stack_full, stack_err);
  endtask

  initial begin
    @(posedge clk); #1;
    // Reset then sequential increment
    step(1, 0, OP_SEQ, 0, 0); lit("rst_pc", 8'h00);
    check("rst_empty", {7'd0, stack_empty}, 8'd1);
    step(0, 0, OP_SEQ, 0, 0); lit("seq1", 8'h01);
    step(0, 0, OP_SEQ, 0, 0); lit("seq2", 8'h02);
    step(0, 0, OP_SEQ, 0, 0); lit("seq3", 8'h03);
    // Wrap and branch
    step(0, 0, OP_JMP, 8'hFE, 0); lit("jmp_fe", 8'hFE);
    step(0, 0, OP_SEQ, 0, 0); lit("wrap_ff", 8'hFF);
    step(0, 0, OP_SEQ, 0, 0); lit("wrap_00", 8'h00);
    step(0, 0, OP_JMP, 8'h20, 0);
    step(0, 0, OP_BR, 0, 8'hF0); lit("br_back", 8'h10);
    step(0, 0, OP_JMP, 8'h20, 0);
    step(0, 0, OP_BR, 0, 8'h05); lit("br_fwd", 8'h25);
    // Nested calls
    step(0, 0, OP_JMP, 8'h04, 0);
    step(0, 0, OP_CALL, 8'h40, 0); lit("call1", 8'h40);
    check("call1_empty", {7'd0, stack_empty}, 8'd0);
    step(0, 0, OP_SEQ, 0, 0);
    step(0, 0, OP_CALL, 8'h80, 0); lit("call2", 8'h80);
    step(0, 0, OP_RET, 0, 0); lit("ret1", 8'h42);
    step(0, 0, OP_RET, 0, 0); lit("ret2", 8'h05);
    check("nest_empty", {7'd0, stack_empty}, 8'd1);
    check("nest_err", {7'd0, stack_err}, 8'd0);
    // Overflow
    step(1, 0, OP_SEQ, 0, 0);
    for (int i = 1; i <= 5; i++) step(0, 0, OP_CALL, W'(i), 0);
    lit("ovf_pc", 8'h05);
    check("ovf_full", {7'd0, stack_full}, 8'd1);
    check("ovf_err", {7'd0, stack_err}, 8'd1);
    step(0, 0, OP_RET, 0, 0); lit("ovf_ret4", 8'h04);
    step(0, 0, OP_RET, 0, 0); lit("ovf_ret3", 8'h03);
    step(0, 0, OP_RET, 0, 0); lit("ovf_ret2", 8'h02);
    step(0, 0, OP_RET, 0, 0); lit("ovf_ret1", 8'h01);
    // Underflow
    step(1, 0, OP_SEQ, 0, 0);
    step(0, 0, OP_RET, 0, 0); lit("udf_pc", 8'h01);
    check("udf_err", {7'd0, stack_err}, 8'd1);
    step(0, 0, OP_SEQ, 0, 0);
    check("udf_sticky", {7'd0, stack_err}, 8'd1);
    step(1, 0, OP_SEQ, 0, 0);
    check("udf_clear", {7'd0, stack_err}, 8'd0);
    // Stall and priority
    step(0, 0, OP_JMP, 8'h33, 0);
    RST = 0; stall = 1; op = OP_CALL; target = 8'h77; #1;
    check("stall_pcnext", pc_next, 8'h33);
    step(0, 1, OP_CALL, 8'h77, 0); lit("stall_pc", 8'h33);
    check("stall_empty", {7'd0, stack_empty}, 8'd1);
    step(0, 0, OP_CALL, 8'h50, 0);
    step(1, 1, OP_CALL, 8'h60, 0); lit("rst_prio_pc", 8'h00);
    check("rst_prio_empty", {7'd0, stack_empty}, 8'd1);
    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic r, s;
      logic [2:0] o;
      r = ($urandom_range(63) == 0);
      s = ($urandom_range(7) == 0);
      o = 3'($urandom_range(7));
      step(r, s, o, W'($urandom), W'($urandom));
    end
    step(0, 0, OP_HOLD, 0, 0);
    @(negedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
